// File: rtl/rf_read_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : rf_read_scoreboard
//  Purpose  : Read side of a REGS x WIDTH register file. It has two
//             combinational-select read ports with registered outputs and one
//             writeback port. A per-register pending-write scoreboard gates
//             the valid/ready operand-read handshake from decode. Writeback
//             data is bypassed into reads in the same cycle.
//  Ports    : clk, rst_n (async assert, active-low)
//             rd_req_valid/rd_req_ready  - operand read handshake from decode
//             rd_addr1/rd_addr2          - source register addresses
//             rd_dest_valid/rd_dest      - destination marked pending on accept
//             rd_rsp_valid               - one-cycle pulse, rd_data1/2 valid
//             rd_data1/rd_data2          - registered operands, held until
//                                          the next accept
//             wb_en/wb_addr/wb_data      - writeback port
//             flush                      - clears every pending bit, blocks
//                                          accept
//             pending                    - registered scoreboard bits
//  Config   : RF_R0_ZERO_EN - register 0 is hard-wired to zero (reads 0,
//             writebacks to it are dropped, never marked pending).
//  Revision : 1.0 - initial release
// ============================================================================
module rf_read_scoreboard #(
    parameter int REGS  = 8,
    parameter int AW    = 3,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_req_valid,
    output logic             rd_req_ready,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    input  logic             rd_dest_valid,
    input  logic [AW-1:0]    rd_dest,
    output logic             rd_rsp_valid,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             flush,
    output logic [REGS-1:0]  pending
);

    logic [WIDTH-1:0] r_mem [REGS];
    logic [REGS-1:0]  r_pending;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_data1;
    logic [WIDTH-1:0] r_data2;

    logic             w_wb_we;
    logic             w_blk1;
    logic             w_blk2;
    logic             w_ready;
    logic             w_accept;
    logic [REGS-1:0]  w_set;
    logic [REGS-1:0]  w_clr;
    logic [WIDTH-1:0] w_rdata1;
    logic [WIDTH-1:0] w_rdata2;

    // Effective storage write enable; register 0 may be read-only zero.
`ifdef RF_R0_ZERO_EN
    assign w_wb_we = wb_en && (wb_addr != '0);
`else
    assign w_wb_we = wb_en;
`endif

    // A source is blocked while pending, unless this cycle's writeback
    // retires it (the data is then bypassed below).
    assign w_blk1   = r_pending[rd_addr1] && !(wb_en && (wb_addr == rd_addr1));
    assign w_blk2   = r_pending[rd_addr2] && !(wb_en && (wb_addr == rd_addr2));
    assign w_ready  = !flush && !w_blk1 && !w_blk2;
    assign w_accept = rd_req_valid && w_ready;

    // Operand select with writeback bypass.
    always_comb begin
        w_rdata1 = r_mem[rd_addr1];
        w_rdata2 = r_mem[rd_addr2];
        if (w_wb_we && (wb_addr == rd_addr1)) w_rdata1 = wb_data;
        if (w_wb_we && (wb_addr == rd_addr2)) w_rdata2 = wb_data;
`ifdef RF_R0_ZERO_EN
        if (rd_addr1 == '0) w_rdata1 = '0;
        if (rd_addr2 == '0) w_rdata2 = '0;
`endif
    end

    // Scoreboard set/clear vectors. Set is applied after clear so that an
    // accept re-marking the register being written back keeps it pending.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_accept && rd_dest_valid) w_set[rd_dest] = 1'b1;
        if (w_wb_we)                   w_clr[wb_addr] = 1'b1;
`ifdef RF_R0_ZERO_EN
        w_set[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (flush) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    generate
        for (genvar i = 0; i < REGS; i++) begin : g_mem
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[i] <= '0;
                end else if (w_wb_we && (wb_addr == AW'(i))) begin
                    r_mem[i] <= wb_data;
                end
            end
        end
    endgenerate

    // Response: pulse on the cycle after accept, data held until next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_data1     <= '0;
            r_data2     <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_data1 <= w_rdata1;
                r_data2 <= w_rdata2;
            end
        end
    end

    assign rd_req_ready = w_ready;
    assign rd_rsp_valid = r_rsp_valid;
    assign rd_data1     = r_data1;
    assign rd_data2     = r_data2;
    assign pending      = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_rf_read_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_read_scoreboard
//  Purpose  : Directed testbench for rf_read_scoreboard with hand-computed
//             expected values. Honors RF_R0_ZERO_EN for the register-0 case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_read_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [2:0]  rd_addr1;
    logic [2:0]  rd_addr2;
    logic        rd_dest_valid;
    logic [2:0]  rd_dest;
    logic        rd_rsp_valid;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flush;
    logic [7:0]  pending;

    int errors = 0;
    int checks = 0;

`ifdef RF_R0_ZERO_EN
    localparam logic [15:0] c_R0_DATA = 16'h0000;
    localparam logic [7:0]  c_R0_PEND = 8'h00;
`else
    localparam logic [15:0] c_R0_DATA = 16'hFFFF;
    localparam logic [7:0]  c_R0_PEND = 8'h01;
`endif

    rf_read_scoreboard #(.REGS(8), .AW(3), .WIDTH(16)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .rd_dest_valid(rd_dest_valid),
        .rd_dest      (rd_dest),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_data1     (rd_data1),
        .rd_data2     (rd_data2),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flush        (flush),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive every input; settle combinational logic before returning.
    task automatic drv(input logic v, input logic [2:0] a1, input logic [2:0] a2,
                       input logic dv, input logic [2:0] d,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic fl);
        rd_req_valid  = v;
        rd_addr1      = a1;
        rd_addr2      = a2;
        rd_dest_valid = dv;
        rd_dest       = d;
        wb_en         = we;
        wb_addr       = wa;
        wb_data       = wd;
        flush         = fl;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        // ---------------- power-on reset ----------------
        #1 rst_n = 1'b0;
        #1;
        chk("por_pending", pending, 8'h00);
        chk("por_rsp", rd_rsp_valid, 1'b0);
        chk("por_d1", rd_data1, 16'h0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("por_ready", rd_req_ready, 1'b1);

        // ---------------- basic read with prior wb ----------------
        drv(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd2, 16'hBEEF, 1'b0);
        cyc();
        drv(1'b1, 3'd2, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
        chk("basic_ready", rd_req_ready, 1'b1);
        cyc();
        chk("basic_rsp", rd_rsp_valid, 1'b1);
        chk("basic_d1", rd_data1, 16'hBEEF);
        chk("basic_d2", rd_data2, 16'h0000);
        idle();
        cyc();
        chk("basic_rsp_drop", rd_rsp_valid, 1'b0);
        chk("basic_d1_hold", rd_data1, 16'hBEEF);

        // ---------------- RAW stall on r3, released by wb ----------------
        drv(1'b1, 3'd0, 3'd0, 1'b1, 3'd3, 1'b0, 3'd0, 16'h0, 1'b0);
        cyc();
        drv(1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("raw_ready", rd_req_ready, 1'b0);
            chk("raw_pending", pending, 8'h08);
            cyc();
            if (k > 0) chk("raw_no_rsp", rd_rsp_valid, 1'b0);
        end
        drv(1'b1, 3'd3, 3'd0, 1'b0, 3'd0, 1'b1, 3'd3, 16'h1234, 1'b0);
        chk("raw_wb_ready", rd_req_ready, 1'b1);
        cyc();
        chk("raw_rsp", rd_rsp_valid, 1'b1);
        chk("raw_d1", rd_data1, 16'h1234);
        chk("raw_pending_clr", pending, 8'h00);

        // ---------------- set/clear collision on r4 ----------------
        drv(1'b1, 3'd0, 3'd0, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0, 1'b0);
        cyc();
        chk("col_pend_a", pending, 8'h10);
        drv(1'b1, 3'd0, 3'd0, 1'b1, 3'd4, 1'b1, 3'd4, 16'h0042, 1'b0);
        chk("col_ready", rd_req_ready, 1'b1);
        cyc();
        chk("col_pend_b", pending, 8'h10);
        drv(1'b1, 3'd4, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
        chk("col_block", rd_req_ready, 1'b0);
        cyc();
        chk("col_block2", rd_req_ready, 1'b0);
        // Flush alone clears pending; the collided wb data must be in r4.
        drv(1'b1, 3'd4, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b1);
        cyc();
        chk("col_flush_pend", pending, 8'h00);
        chk("col_flush_rsp", rd_rsp_valid, 1'b0);
        drv(1'b1, 3'd4, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
        cyc();
        chk("col_r4_data", rd_data1, 16'h0042);

        // ---------------- flush with pending=F0 and wb r1 ----------------
        for (int r = 4; r < 8; r++) begin
            drv(1'b1, 3'd2, 3'd2, 1'b1, 3'(r), 1'b0, 3'd0, 16'h0, 1'b0);
            cyc();
        end
        chk("fl_pend_f0", pending, 8'hF0);
        drv(1'b1, 3'd0, 3'd0, 1'b1, 3'd2, 1'b1, 3'd1, 16'h0007, 1'b1);
        chk("fl_ready", rd_req_ready, 1'b0);
        cyc();
        chk("fl_rsp", rd_rsp_valid, 1'b0);
        chk("fl_pend", pending, 8'h00);
        drv(1'b1, 3'd1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
        chk("fl_ready_after", rd_req_ready, 1'b1);
        cyc();
        chk("fl_r1_d1", rd_data1, 16'h0007);
        chk("fl_r1_d2", rd_data2, 16'h0007);

        // ---------------- async reset mid-stall ----------------
        drv(1'b1, 3'd1, 3'd1, 1'b1, 3'd3, 1'b0, 3'd0, 16'h0, 1'b0);
        cyc();
        drv(1'b1, 3'd3, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
        chk("rst_stall_ready", rd_req_ready, 1'b0);
        chk("rst_stall_pend", pending, 8'h08);
        chk("rst_stall_d1", rd_data1, 16'h0007);
        rst_n = 1'b0;
        #1;
        chk("rst_pend", pending, 8'h00);
        chk("rst_rsp", rd_rsp_valid, 1'b0);
        chk("rst_d1", rd_data1, 16'h0);
        chk("rst_d2", rd_data2, 16'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", rd_req_ready, 1'b1);
        cyc();
        chk("rst_read_rsp", rd_rsp_valid, 1'b1);
        chk("rst_read_d2", rd_data2, 16'h0000);

        // ---------------- register 0 behaviour ----------------
        drv(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 16'hFFFF, 1'b0);
        cyc();
        drv(1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 16'h0, 1'b0);
        cyc();
        chk("r0_rsp", rd_rsp_valid, 1'b1);
        chk("r0_d1", rd_data1, {16'h0, c_R0_DATA});
        chk("r0_pend", pending, {24'h0, c_R0_PEND});
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net: the directed sequence is short; never hang.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
